rocc_load_streamer: RTL and testbench

Load-side memory front end inside the accelerator. It sits between the command decoder and the rocc_mem_req/rocc_mem_resp port that drives ExtMem. It accepts a (base address, word count) job and issues sequential 64-bit load requests with up to MAX_OUT in flight. Responses may return out of order by tag; the block reorders them and delivers an in-order valid/ready word stream, with a last flag, to the compute datapath.

---
 rtl/rocc_mem_pkg.sv | 22 ++
 rtl/load_rob.sv | 64 ++++++
 rtl/rocc_load_streamer.sv | 144 ++++++++++++++
 tb/tb_rocc_load_streamer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_mem_pkg.sv
// Shared memory-command constants, FSM state type and word geometry for the load streamer.
package rocc_mem_pkg;

  localparam logic [4:0] M_XRD = 5'd0;
  localparam logic [4:0] M_XWR = 5'd1;
  localparam logic [1:0] MT_D  = 2'd3;

  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } ls_state_e;

  // Slot index width; a single-entry buffer still needs one bit to address it.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/load_rob.sv
// Tag-indexed reorder buffer: per-slot reserved/valid bits, one write port, one head read port.
module load_rob
  import rocc_mem_pkg::*;
#(
  parameter  int unsigned XLEN    = 64,
  parameter  int unsigned TAG_W   = 8,
  parameter  int unsigned MAX_OUT = 4,
  localparam int unsigned IDX_W   = idx_width(MAX_OUT)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rsv_i,
  input  logic [IDX_W-1:0] rsv_idx_i,
  input  logic             wr_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [XLEN-1:0]  wr_data_i,
  input  logic             pop_i,
  input  logic [IDX_W-1:0] head_idx_i,
  output logic             head_valid_o,
  output logic [XLEN-1:0]  head_data_o,
  output logic             wr_err_o
);

  logic [MAX_OUT-1:0] rsv_q;
  logic [MAX_OUT-1:0] vld_q;
  logic [XLEN-1:0]    data_q [MAX_OUT];
  logic [IDX_W-1:0]   wr_idx;
  logic               wr_in_range;
  logic               wr_ok;

  assign wr_idx      = wr_tag_i[IDX_W-1:0];
  assign wr_in_range = 32'(wr_tag_i) < MAX_OUT;
  // A write is legal only into a slot that has an outstanding request and no data yet.
  assign wr_ok       = wr_i && wr_in_range && rsv_q[wr_idx] && !vld_q[wr_idx];
  assign wr_err_o    = wr_i && !wr_ok;

  assign head_valid_o = vld_q[head_idx_i];
  assign head_data_o  = data_q[head_idx_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsv_q <= '0;
      vld_q <= '0;
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        if (pop_i && head_idx_i == IDX_W'(i)) begin
          rsv_q[i] <= 1'b0;
          vld_q[i] <= 1'b0;
        end
        if (rsv_i && rsv_idx_i == IDX_W'(i)) begin
          rsv_q[i] <= 1'b1;
        end
        if (wr_ok && wr_idx == IDX_W'(i)) begin
          vld_q[i]  <= 1'b1;
          data_q[i] <= wr_data_i;
        end
      end
    end
  end

endmodule

// File: rtl/rocc_load_streamer.sv
// Issues sequential 64-bit loads for a (base, length) job and streams the reordered words in order.
module rocc_load_streamer
  import rocc_mem_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ADDR_W  = 40,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [TAG_W-1:0]  mem_req_tag,
  output logic [4:0]        mem_req_cmd,
  output logic [1:0]        mem_req_size,
  output logic              mem_req_phys,
  output logic              mem_req_signed,
  output logic [7:0]        mem_req_mask,
  output logic [XLEN-1:0]   mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [TAG_W-1:0]  mem_resp_tag,
  input  logic              mem_resp_has_data,
  input  logic [XLEN-1:0]   mem_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              tag_err
);

  localparam int unsigned IDX_W = idx_width(MAX_OUT);

  ls_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issue_q, issue_d;
  logic [LEN_W-1:0]  drain_q, drain_d;
  logic              tag_err_q, tag_err_d;

  logic [LEN_W-1:0]  in_flight;
  logic              req_fire;
  logic              out_fire;
  logic              rob_wr_err;

  assign in_flight     = issue_q - drain_q;
  assign mem_req_valid = (state_q == ST_RUN) && (issue_q < len_q) && (32'(in_flight) < MAX_OUT);
  assign mem_req_addr  = addr_q + (ADDR_W'(issue_q) << WORD_SHIFT);
  assign mem_req_tag   = TAG_W'(issue_q[IDX_W-1:0]);

  assign mem_req_cmd    = M_XRD;
  assign mem_req_size   = MT_D;
  assign mem_req_phys   = 1'b0;
  assign mem_req_signed = 1'b0;
  assign mem_req_mask   = 8'hFF;
  assign mem_req_data   = '0;

  assign req_fire = mem_req_valid && mem_req_ready;
  assign out_fire = (state_q == ST_RUN) && out_valid && out_ready;
  assign out_last = (drain_q == len_q - LEN_W'(1));

  assign start_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign tag_err     = tag_err_q;

  load_rob #(
    .XLEN   (XLEN),
    .TAG_W  (TAG_W),
    .MAX_OUT(MAX_OUT)
  ) u_rob (
    .clk_i       (clock),
    .rst_ni      (reset),
    .rsv_i       (req_fire),
    .rsv_idx_i   (issue_q[IDX_W-1:0]),
    .wr_i        (mem_resp_valid && mem_resp_has_data),
    .wr_tag_i    (mem_resp_tag),
    .wr_data_i   (mem_resp_data),
    .pop_i       (out_fire),
    .head_idx_i  (drain_q[IDX_W-1:0]),
    .head_valid_o(out_valid),
    .head_data_o (out_data),
    .wr_err_o    (rob_wr_err)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    issue_d   = issue_q;
    drain_d   = drain_q;
    tag_err_d = tag_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          addr_d    = start_addr;
          len_d     = start_len;
          issue_d   = '0;
          drain_d   = '0;
          tag_err_d = 1'b0;
          state_d   = (start_len == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (req_fire) issue_d = issue_q + LEN_W'(1);
        if (out_fire) begin
          drain_d = drain_q + LEN_W'(1);
          if (out_last) state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // An illegal response in the same cycle as a new start still leaves the flag set.
    if (rob_wr_err) tag_err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      issue_q   <= '0;
      drain_q   <= '0;
      tag_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      issue_q   <= issue_d;
      drain_q   <= drain_d;
      tag_err_q <= tag_err_d;
    end
  end

endmodule

// File: tb/tb_rocc_load_streamer.sv
// Scoreboard bench: jobs push expected requests/words; monitors and a memory model check the stream.
module tb_rocc_load_streamer;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ADDR_W  = 40;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned MAX_OUT = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start_valid = 1'b0;
  logic              start_ready;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [LEN_W-1:0]  start_len = '0;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [TAG_W-1:0]  mem_req_tag;
  logic [4:0]        mem_req_cmd;
  logic [1:0]        mem_req_size;
  logic              mem_req_phys;
  logic              mem_req_signed;
  logic [7:0]        mem_req_mask;
  logic [XLEN-1:0]   mem_req_data;
  logic              mem_resp_valid = 1'b0;
  logic [TAG_W-1:0]  mem_resp_tag = '0;
  logic              mem_resp_has_data = 1'b0;
  logic [XLEN-1:0]   mem_resp_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [XLEN-1:0]   out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              tag_err;

  rocc_load_streamer #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clock(clock), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_addr(start_addr), .start_len(start_len),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_cmd(mem_req_cmd), .mem_req_size(mem_req_size),
    .mem_req_phys(mem_req_phys), .mem_req_signed(mem_req_signed),
    .mem_req_mask(mem_req_mask), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
    .mem_resp_has_data(mem_resp_has_data), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .tag_err(tag_err)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [TAG_W-1:0] tag; } req_t;
  typedef struct packed { logic [XLEN-1:0] data; logic last; } word_t;
  typedef struct packed { logic [TAG_W-1:0] tag; logic [XLEN-1:0] data; } resp_t;

  req_t  exp_req_q[$];
  word_t exp_out_q[$];
  resp_t pend_q[$];
  logic [XLEN-1:0] mem_init [logic [ADDR_W-1:0]];

  int total = 0;
  int bad   = 0;
  int mem_mode = 0;      // 0 in order, 1 random order with gaps, 2 hold four then release in perm order
  int req_rdy_mode = 0;  // 0 always, 1 random, 2 never
  int out_rdy_mode = 0;
  int perm [4] = '{2, 0, 3, 1};
  int perm_left = 0;
  bit stray_go = 1'b0;
  logic [TAG_W-1:0] stray_tag = '0;
  int job_reqs = 0;
  int job_outs = 0;
  bit done_due = 1'b0;
  bit prev_wait = 1'b0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] mem_word(input logic [ADDR_W-1:0] a);
    if (mem_init.exists(a)) return mem_init[a];
    return {~a[23:0], a};
  endfunction

  function automatic logic rdy(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(1));
    return 1'b0;
  endfunction

  // Memory model and consumer: drives responses and ready signals just after each rising edge.
  always @(posedge clock) begin
    int sel;
    #1;
    mem_resp_valid    = 1'b0;
    mem_resp_has_data = 1'b0;
    mem_resp_tag      = '0;
    mem_resp_data     = '0;
    mem_req_ready     = rdy(req_rdy_mode);
    out_ready         = rdy(out_rdy_mode);
    sel = -1;
    if (stray_go) begin
      mem_resp_valid    = 1'b1;
      mem_resp_has_data = 1'b1;
      mem_resp_tag      = stray_tag;
      mem_resp_data     = 64'hDEAD_0000_BAD0_0000;
      stray_go          = 1'b0;
    end else if (pend_q.size() > 0) begin
      if (mem_mode == 0) sel = 0;
      else if (mem_mode == 1) begin
        if ($urandom_range(3) != 0) sel = int'($urandom_range(pend_q.size() - 1));
      end else begin
        if (perm_left == 0 && pend_q.size() == 4) perm_left = 4;
        if (perm_left > 0) begin
          for (int k = 0; k < pend_q.size(); k++)
            if (int'(pend_q[k].tag) == perm[4 - perm_left]) sel = k;
          perm_left--;
        end
      end
    end else if (mem_mode == 1 && $urandom_range(7) == 0) begin
      mem_resp_valid    = 1'b1;
      mem_resp_has_data = 1'b0;
      mem_resp_tag      = TAG_W'($urandom);
      mem_resp_data     = {$urandom, $urandom};
    end
    if (sel >= 0) begin
      mem_resp_valid    = 1'b1;
      mem_resp_has_data = 1'b1;
      mem_resp_tag      = pend_q[sel].tag;
      mem_resp_data     = pend_q[sel].data;
      pend_q.delete(sel);
    end
  end

  // Monitor: inputs are stable here, so valid&ready seen now is the handshake at the next edge.
  always @(negedge clock) begin
    if (!reset) begin
      done_due  = 1'b0;
      prev_wait = 1'b0;
    end else begin
      check("done", 64'(done), 64'(done_due));
      done_due = 1'b0;
      if (start_valid && start_ready && start_len == '0) done_due = 1'b1;

      if (prev_wait) check("req_hold", 64'(mem_req_valid), 64'd1);
      prev_wait = mem_req_valid && !mem_req_ready;
      if (exp_req_q.size() == 0) check("req_unexpected", 64'(mem_req_valid), 64'd0);
      else if (mem_req_valid) begin
        check("req_addr", 64'(mem_req_addr), 64'(exp_req_q[0].addr));
        check("req_tag", 64'(mem_req_tag), 64'(exp_req_q[0].tag));
        check("req_const", 64'({mem_req_cmd, mem_req_size, mem_req_phys, mem_req_signed, mem_req_mask}),
              64'({5'd0, 2'd3, 1'b0, 1'b0, 8'hFF}));
        check("req_data", mem_req_data, 64'd0);
        if (mem_req_ready) begin
          pend_q.push_back('{tag: exp_req_q[0].tag, data: mem_word(exp_req_q[0].addr)});
          void'(exp_req_q.pop_front());
          job_reqs++;
        end
      end

      if (exp_out_q.size() == 0) check("out_unexpected", 64'(out_valid), 64'd0);
      else if (out_valid) begin
        check("out_data", out_data, exp_out_q[0].data);
        check("out_last", 64'(out_last), 64'(exp_out_q[0].last));
        if (out_ready) begin
          if (exp_out_q[0].last) done_due = 1'b1;
          void'(exp_out_q.pop_front());
          job_outs++;
        end
      end
    end
  end

  task automatic start_job(input logic [ADDR_W-1:0] a, input int len);
    int guard = 0;
    @(negedge clock);
    while (start_ready !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    check("start_ready_idle", 64'(start_ready), 64'd1);
    @(posedge clock);
    #1;
    start_valid = 1'b1;
    start_addr  = a;
    start_len   = LEN_W'(len);
    job_reqs    = 0;
    job_outs    = 0;
    for (int i = 0; i < len; i++) begin
      exp_req_q.push_back('{addr: a + ADDR_W'(i * 8), tag: TAG_W'(i % MAX_OUT)});
      exp_out_q.push_back('{data: mem_word(a + ADDR_W'(i * 8)), last: (i == len - 1)});
    end
    @(posedge clock);
    #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 2000 && (exp_out_q.size() != 0 || start_ready !== 1'b1)) begin
      @(negedge clock);
      n++;
    end
    check("job_words_left", 64'(exp_out_q.size()), 64'd0);
    check("job_reqs_left", 64'(exp_req_q.size()), 64'd0);
    check("job_back_idle", 64'(start_ready), 64'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_start_ready", 64'(start_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_req_addr", 64'(mem_req_addr), 64'd0);
    check("rst_req_tag", 64'(mem_req_tag), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_tag_err", 64'(tag_err), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [ADDR_W-1:0] ra;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs();
    @(posedge clock);
    #3 reset = 1'b1;

    // Basic in-order job
    for (int i = 0; i < 4; i++) mem_init[40'h100 + ADDR_W'(i * 8)] = 64'hA0 + 64'(i);
    start_job(40'h100, 4);
    wait_idle();
    check("basic_tag_err", 64'(tag_err), 64'd0);

    // Responses return with tags 2,0,3,1
    for (int i = 0; i < 4; i++) mem_init[40'h200 + ADDR_W'(i * 8)] = 64'hA0 + 64'(i);
    mem_mode = 2;
    start_job(40'h200, 4);
    wait_idle();
    check("ooo_tag_err", 64'(tag_err), 64'd0);
    mem_mode = 0;

    // Consumer stalled: issue must stop at four outstanding; starts outside IDLE are ignored
    out_rdy_mode = 2;
    start_job(40'h3000, 8);
    @(posedge clock);
    #1;
    start_valid = 1'b1;
    start_addr  = 40'h0BAD0;
    start_len   = 16'd3;
    repeat (20) @(negedge clock);
    check("bp_start_ready", 64'(start_ready), 64'd0);
    check("bp_busy", 64'(busy), 64'd1);
    check("bp_issued", 64'(job_reqs), 64'd4);
    check("bp_req_valid", 64'(mem_req_valid), 64'd0);
    @(posedge clock);
    #1;
    start_valid = 1'b0;
    start_len   = '0;
    out_rdy_mode = 0;
    wait_idle();

    // Zero-length job
    start_job(40'h5000, 0);
    @(negedge clock);
    check("zl_done", 64'(done), 64'd1);
    check("zl_req_valid", 64'(mem_req_valid), 64'd0);
    @(negedge clock);
    check("zl_start_ready", 64'(start_ready), 64'd1);
    check("zl_done_clear", 64'(done), 64'd0);

    // Request stall holds address/tag; stray out-of-range tag flags an error
    req_rdy_mode = 2;
    start_job(40'h6000, 6);
    repeat (5) @(negedge clock);
    check("stall_req_valid", 64'(mem_req_valid), 64'd1);
    check("stall_req_addr", 64'(mem_req_addr), 64'h6000);
    check("stall_req_tag", 64'(mem_req_tag), 64'd0);
    stray_tag = 8'd7;
    stray_go  = 1'b1;
    req_rdy_mode = 0;
    repeat (3) @(negedge clock);
    check("stray_tag_err", 64'(tag_err), 64'd1);
    wait_idle();
    check("tag_err_sticky", 64'(tag_err), 64'd1);
    start_job(40'h7000, 3);
    @(negedge clock);
    check("tag_err_cleared", 64'(tag_err), 64'd0);
    wait_idle();

    // Reset in the middle of a job, then a stale response and a fresh job
    start_job(40'h8000, 6);
    n = 0;
    while (job_outs < 2 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("mid_words_seen", 64'(job_outs >= 2), 64'd1);
    @(posedge clock);
    #3;
    reset = 1'b0;
    exp_req_q.delete();
    exp_out_q.delete();
    pend_q.delete();
    perm_left = 0;
    @(negedge clock);
    check_reset_outputs();
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    stray_tag = 8'd1;
    stray_go  = 1'b1;
    repeat (3) @(negedge clock);
    check("stale_resp_err", 64'(tag_err), 64'd1);
    start_job(40'h9000, 2);
    @(negedge clock);
    check("post_rst_err_clear", 64'(tag_err), 64'd0);
    wait_idle();

    // Randomized jobs with random memory order, request stalls and consumer stalls
    mem_mode = 1;
    req_rdy_mode = 1;
    out_rdy_mode = 1;
    for (int j = 0; j < 25; j++) begin
      ra = {8'($urandom), $urandom} & ~40'h7;
      if (j == 3) start_job(40'hFF_FFFF_FFF0, 5);
      else start_job(ra, int'($urandom_range(12)));
      wait_idle();
      check("rand_tag_err", 64'(tag_err), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
